// File: rtl/spi_byte_shifter_pkg.sv
// -----------------------------------------------------------------------------
// spi_byte_shifter_pkg
// Shared definitions for the SPI byte shifter: FSM state encoding, the SPI mode
// this engine implements and the default transfer geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_byte_shifter_pkg;

   // FSM states of the bit engine.
   typedef enum logic [1:0] {
      SH_IDLE = 2'd0,
      SH_LOW  = 2'd1,
      SH_HIGH = 2'd2,
      SH_DONE = 2'd3
   } shift_state_t;

   // {CPOL, CPHA}: clock idles low, data sampled on the rising edge.
   localparam logic [1:0] SPI_MODE0 = 2'b00;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_HALF_DIV   = 6;

endpackage

// File: rtl/spi_byte_shifter_if.sv
// -----------------------------------------------------------------------------
// spi_byte_shifter_if
// Per-byte handshake between the transaction controller (master) and the
// bit-level shifter (slave).
//   tx_en      controller -> shifter  active-low byte request (level)
//   tx_byte    controller -> shifter  byte to send, latched when a byte starts
//   byte_done  shifter -> controller  completion pulse; controller acts on its fall
//   rx_byte    shifter -> controller  last completed received byte
//   busy       shifter -> controller  high while a byte is in flight
// Handshake: the shifter looks at tx_en only while idle; a request seen low
// there is accepted on that clock edge and the byte always runs to completion.
// -----------------------------------------------------------------------------
interface spi_byte_shifter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tx_en;
   logic [DATA_WIDTH-1:0] tx_byte;
   logic                  byte_done;
   logic [DATA_WIDTH-1:0] rx_byte;
   logic                  busy;

   modport master (
      output tx_en,
      output tx_byte,
      input  byte_done,
      input  rx_byte,
      input  busy
   );

   modport slave (
      input  tx_en,
      input  tx_byte,
      output byte_done,
      output rx_byte,
      output busy
   );
endinterface

// File: rtl/spi_byte_shifter_half_timer.sv
// -----------------------------------------------------------------------------
// spi_byte_shifter_half_timer
// Half-period divider for the SPI clock. Counts 0..HALF_DIV-1 and flags the
// terminal count; wraps to zero on the terminal count and on clear.
//   sysClk  in   system clock
//   reset   in   synchronous, active-low
//   clr_i   in   synchronous clear (held while the shifter is idle)
//   tc_o    out  high during the last cycle of a half-period
// -----------------------------------------------------------------------------
module spi_byte_shifter_half_timer #(
   parameter int HALF_DIV = 6
) (
   input  logic sysClk,
   input  logic reset,
   input  logic clr_i,
   output logic tc_o
);

   localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;

   assign tc_o = (div_cnt_q == DIV_LAST);

   always_comb begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      if (clr_i || tc_o) begin
         div_cnt_d = '0;
      end
   end

   always_ff @(posedge sysClk) begin
      if (!reset) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/spi_byte_shifter.sv
// -----------------------------------------------------------------------------
// spi_byte_shifter
// SPI mode-0 bit engine. Sends one DATA_WIDTH byte MSB-first on mosi while
// capturing one byte from miso, generating its own gated SPI clock from sysClk.
//   sysClk   in   system clock, rising edge
//   reset    in   synchronous, active-low
//   miso     in   serial data from slave, sampled on spiClk rise
//   spiClk   out  gated SPI clock, low whenever not shifting
//   mosi     out  serial data to slave, MSB first
//   state_o  out  current FSM state (shift_state_t encoding), for observation
//   bus      slave side of the controller handshake (tx_en, tx_byte,
//            byte_done, rx_byte, busy)
// Every output is driven straight from a register.
// -----------------------------------------------------------------------------
module spi_byte_shifter
   import spi_byte_shifter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int HALF_DIV   = DEF_HALF_DIV
) (
   input  logic                   sysClk,
   input  logic                   reset,
   input  logic                   miso,
   output logic                   spiClk,
   output logic                   mosi,
   output logic [1:0]             state_o,
   spi_byte_shifter_if.slave      bus
);

   localparam logic [1:0] IDLE = SH_IDLE;
   localparam logic [1:0] LOW  = SH_LOW;
   localparam logic [1:0] HIGH = SH_HIGH;
   localparam logic [1:0] DONE = SH_DONE;

   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   logic [1:0]            state_q,   state_d;
   logic [DATA_WIDTH-1:0] tx_sr_q,   tx_sr_d;
   logic [DATA_WIDTH-1:0] rx_sr_q,   rx_sr_d;
   logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  spi_clk_q, spi_clk_d;
   logic                  mosi_q,    mosi_d;
   logic                  done_q,    done_d;
   logic                  busy_q;
   logic                  half_tc;

   // One timer serves LOW, HIGH and DONE: it is held at zero while idle, so
   // every non-idle state starts a fresh half-period, and it self-wraps on
   // each terminal count as the FSM moves on.
   spi_byte_shifter_half_timer #(
      .HALF_DIV (HALF_DIV)
   ) u_half_timer (
      .sysClk (sysClk),
      .reset  (reset),
      .clr_i  (state_q == IDLE),
      .tc_o   (half_tc)
   );

   always_comb begin
      state_d   = state_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_byte_d = rx_byte_q;
      bit_cnt_d = bit_cnt_q;
      spi_clk_d = spi_clk_q;
      mosi_d    = mosi_q;
      done_d    = done_q;

      case (state_q)
         IDLE: begin
            spi_clk_d = 1'b0;
            mosi_d    = 1'b0;
            done_d    = 1'b0;
            if (!bus.tx_en) begin
               tx_sr_d   = bus.tx_byte;
               mosi_d    = bus.tx_byte[DATA_WIDTH-1];
               bit_cnt_d = '0;
               state_d   = LOW;
            end
         end

         LOW: begin
            if (half_tc) begin
               spi_clk_d = 1'b1;
               rx_sr_d   = {rx_sr_q[DATA_WIDTH-2:0], miso};
               state_d   = HIGH;
            end
         end

         HIGH: begin
            if (half_tc) begin
               spi_clk_d = 1'b0;
               if (bit_cnt_q == BIT_LAST) begin
                  // rx_sr already holds all bits: the last one was taken at
                  // the rising edge that opened this half-period.
                  rx_byte_d = rx_sr_q;
                  done_d    = 1'b1;
                  state_d   = DONE;
               end else begin
                  tx_sr_d   = tx_sr_q << 1;
                  mosi_d    = tx_sr_d[DATA_WIDTH-1];
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  state_d   = LOW;
               end
            end
         end

         DONE: begin
            // mosi keeps the last bit until the pulse ends.
            if (half_tc) begin
               done_d  = 1'b0;
               mosi_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d   = IDLE;
            spi_clk_d = 1'b0;
            mosi_d    = 1'b0;
            done_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sysClk) begin
      if (!reset) begin
         state_q   <= IDLE;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_byte_q <= '0;
         bit_cnt_q <= '0;
         spi_clk_q <= 1'b0;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_byte_q <= rx_byte_d;
         bit_cnt_q <= bit_cnt_d;
         spi_clk_q <= spi_clk_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
         busy_q    <= (state_d != IDLE);
      end
   end

   assign spiClk        = spi_clk_q;
   assign mosi          = mosi_q;
   assign state_o       = state_q;
   assign bus.byte_done = done_q;
   assign bus.rx_byte   = rx_byte_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_shifter
// Directed bench for spi_byte_shifter with DATA_WIDTH=8, HALF_DIV=6.
// -----------------------------------------------------------------------------
module tb_spi_byte_shifter;

   localparam int DW  = 8;
   localparam int HD  = 6;
   localparam int BYTE_CYC = 2 * DW * HD;

   // ---------------- clock / reset ----------------
   logic sysClk = 1'b0;
   logic reset  = 1'b0;
   always #5 sysClk = ~sysClk;

   // ---------------- DUT ----------------
   logic       miso;
   logic       spiClk;
   logic       mosi;
   logic [1:0] state_o;
   int         miso_mode = 0;   // 0: tie 0, 1: tie 1, 2: loopback

   spi_byte_shifter_if #(.DATA_WIDTH(DW)) bus ();

   spi_byte_shifter #(
      .DATA_WIDTH (DW),
      .HALF_DIV   (HD)
   ) dut (
      .sysClk  (sysClk),
      .reset   (reset),
      .miso    (miso),
      .spiClk  (spiClk),
      .mosi    (mosi),
      .state_o (state_o),
      .bus     (bus)
   );

   always_comb begin
      miso = 1'b0;
      if (miso_mode == 2)      miso = mosi;
      else if (miso_mode == 1) miso = 1'b1;
   end

   // ---------------- scoreboard / counters ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] exp_q[$];
   logic          rise_bits[$];
   logic          spi_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // mosi as seen on each spiClk rise, plus the idle-clock invariant.
   always @(negedge sysClk) begin
      if (spiClk && !spi_prev) rise_bits.push_back(mosi);
      spi_prev <= spiClk;
      if (reset && !bus.busy && spiClk) begin
         n_fail++;
         $display("FAIL spiclk_idle: spiClk=%0b while busy=0", spiClk);
      end
   end

   function automatic logic [DW-1:0] rise_word();
      logic [DW-1:0] w;
      w = '0;
      foreach (rise_bits[i]) w = {w[DW-2:0], rise_bits[i]};
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply_reset(input int cycles);
      @(negedge sysClk);
      reset = 1'b0;
      repeat (cycles) @(negedge sysClk);
      reset = 1'b1;
   endtask

   // Sends one byte with tx_en pulsed for the accepting edge only (or, when
   // disturb is set, held low until mid-byte and released together with a
   // change of tx_byte). Checks timing, serial pattern and received byte.
   task automatic run_byte(input logic [DW-1:0] b, input int mode,
                           input logic [DW-1:0] exp_rx, input bit disturb,
                           input string tag);
      int n;
      int w;
      @(negedge sysClk);
      miso_mode   = mode;
      bus.tx_byte = b;
      bus.tx_en   = 1'b0;
      exp_q.push_back(exp_rx);
      rise_bits.delete();
      @(posedge sysClk);           // T0
      #1;
      if (!disturb) bus.tx_en = 1'b1;
      n = 0;
      while (!bus.byte_done && n < BYTE_CYC + 50) begin
         @(negedge sysClk);
         n++;
         if (disturb && n == 30) begin
            bus.tx_byte = 8'h00;
            bus.tx_en   = 1'b1;
         end
      end
      check({tag, "_done_latency"}, n - 1, BYTE_CYC);
      check({tag, "_rx_byte"}, bus.rx_byte, exp_q.pop_front());
      check({tag, "_rises"}, rise_bits.size(), DW);
      check({tag, "_mosi_bits"}, rise_word(), b);
      w = 0;
      while (bus.byte_done && w < 50) begin
         w++;
         @(negedge sysClk);
      end
      check({tag, "_done_width"}, w, HD);
      check({tag, "_idle_after"}, {bus.busy, spiClk, mosi, state_o}, 5'b0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [DW-1:0] tx;
      int            mode;
      logic [DW-1:0] exp_rx;
   } vec_t;

   vec_t vecs[6];

   // ---------------- test body ----------------
   initial begin : main
      int n;
      int gap;
      bit seen;

      vecs[0] = '{8'hA5, 2, 8'hA5};
      vecs[1] = '{8'h3C, 1, 8'hFF};
      vecs[2] = '{8'h00, 1, 8'hFF};
      vecs[3] = '{8'hC3, 0, 8'h00};
      vecs[4] = '{8'h81, 2, 8'h81};
      vecs[5] = '{8'h7E, 2, 8'h7E};

      bus.tx_en   = 1'b1;
      bus.tx_byte = '0;
      apply_reset(3);
      @(negedge sysClk);
      check("reset_outputs",
            {bus.busy, bus.byte_done, spiClk, mosi, state_o, bus.rx_byte},
            '0);

      for (int i = 0; i < 6; i++) begin
         run_byte(vecs[i].tx, vecs[i].mode, vecs[i].exp_rx, 1'b0,
                  $sformatf("vec%0d", i));
      end

      // Reset one cycle, 40 cycles into a byte.
      @(negedge sysClk);
      miso_mode   = 2;
      bus.tx_byte = 8'hC3;
      bus.tx_en   = 1'b0;
      @(posedge sysClk);
      #1 bus.tx_en = 1'b1;
      repeat (40) @(negedge sysClk);
      check("pre_reset_busy", bus.busy, 1'b1);
      reset = 1'b0;
      @(negedge sysClk);
      reset = 1'b1;
      check("midreset_outputs", {bus.busy, spiClk, mosi, state_o, bus.rx_byte}, '0);
      seen = 1'b0;
      repeat (BYTE_CYC + 20) begin
         @(negedge sysClk);
         if (bus.byte_done || bus.busy) seen = 1'b1;
      end
      check("midreset_no_done", seen, 1'b0);
      run_byte(8'h5A, 2, 8'h5A, 1'b0, "post_reset");

      // Back-to-back with tx_en held low.
      @(negedge sysClk);
      miso_mode   = 2;
      bus.tx_byte = 8'h12;
      bus.tx_en   = 1'b0;
      n = 0;
      while (!bus.byte_done && n < BYTE_CYC + 50) begin
         @(negedge sysClk);
         n++;
      end
      check("b2b_first_rx", bus.rx_byte, 8'h12);
      bus.tx_byte = 8'h34;
      n = 0;
      while (bus.byte_done && n < 50) begin
         @(negedge sysClk);
         n++;
      end
      gap = 0;
      while (!bus.busy && gap < 10) begin
         gap++;
         @(negedge sysClk);
      end
      check("b2b_idle_gap", gap, 1);
      bus.tx_en = 1'b1;
      n = 0;
      while (!bus.byte_done && n < BYTE_CYC + 50) begin
         @(negedge sysClk);
         n++;
      end
      check("b2b_second_latency", n, BYTE_CYC);
      check("b2b_second_rx", bus.rx_byte, 8'h34);
      n = 0;
      while (bus.byte_done && n < 50) begin
         @(negedge sysClk);
         n++;
      end
      repeat (3) @(negedge sysClk);
      check("b2b_stays_idle", {bus.busy, state_o}, 3'b0);

      // tx_byte and tx_en disturbed mid-byte.
      run_byte(8'hF0, 2, 8'hF0, 1'b1, "disturb");

      repeat (5) @(negedge sysClk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
